global_st_arbiter: RTL and testbench

- Shares the single global-memory write port between N_PE per-PE store units (their global store FIFO outputs).
- Round-robin arbitration picks at most one requester per cycle. The winning addr/data go into a one-entry output register that drives the memory port.
- Also runs a flush handshake: the top-level controller uses it to learn when every store, buffered or in flight, has reached global memory.

---
 rtl/pe_pkg.sv | 61 ++++++
 rtl/global_st_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/global_st_arbiter.sv | 171 +++++++++++++++++
 tb/tb_global_st_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared PE-array definitions used by the global store arbiter.
//   global_st_arb_state_t : flush FSM states (RUN, FLUSH, DONE)
//   N_PE_ST_ARB           : default number of store requesters
//   GLOBAL_MEM_ADDR_L     : default global memory address width
//   DATA_L                : default data word width
//   rr_first_set()        : round-robin search helper, returns winner + valid
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int N_PE_ST_ARB       = 8;
  localparam int GLOBAL_MEM_ADDR_L = 16;
  localparam int DATA_L            = 32;

  // The search helper works on a fixed maximum width so one function serves
  // every arbiter size up to RR_MAX_N requesters.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } global_st_arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or after ptr, wrapping n-1 -> 0.
  // cand stays below 2*n, so one conditional subtract is the full modulo
  // and non-power-of-two n works.
  function automatic rr_pick_t rr_first_set(
    input logic [RR_MAX_N-1:0] req,
    input logic [RR_IDX_W-1:0] ptr,
    input logic [RR_IDX_W:0]   n
  );
    rr_pick_t            pick;
    logic [RR_IDX_W:0]   cand;
    pick.valid = 1'b0;
    pick.idx   = {RR_IDX_W{1'b0}};
    for (int k = 0; k < RR_MAX_N; k++) begin
      cand = {1'b0, ptr} + k[RR_IDX_W:0];
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((k[RR_IDX_W:0] < n) && !pick.valid && req[cand[RR_IDX_W-1:0]]) begin
        pick.valid = 1'b1;
        pick.idx   = cand[RR_IDX_W-1:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/global_st_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Parameterised round-robin core with its own pointer register.
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req        : request vector
//   i_advance    : grant allowed this cycle; the pointer moves only on a grant
//   o_gnt        : one-hot grant (all zero when no grant)
//   o_winner     : index of the granted requester
//   o_valid      : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter
  import pe_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_winner,
  output logic          o_valid
);

  localparam logic [RR_IDX_W:0] N_W = (RR_IDX_W+1)'(N);
  localparam logic [PW-1:0]     LAST = PW'(N - 1);

  logic [PW-1:0]       r_ptr;
  logic [RR_MAX_N-1:0] w_req_ext;
  rr_pick_t            w_pick;
  logic [RR_IDX_W-1:0] w_unused_idx;

  assign w_req_ext    = RR_MAX_N'(i_req);
  assign w_pick       = rr_first_set(w_req_ext, RR_IDX_W'(r_ptr), N_W);
  assign w_unused_idx = w_pick.idx;
  assign o_winner     = w_pick.idx[PW-1:0];
  assign o_valid      = w_pick.valid & i_advance;

  // One-hot decode of the winner index.
  always_comb begin
    o_gnt = {N{1'b0}};
    if (o_valid) begin
      o_gnt[o_winner] = 1'b1;
    end else begin
      o_gnt = {N{1'b0}};
    end
  end

  // Pointer moves to the slot after the winner, with explicit wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= {PW{1'b0}};
    end else if (o_valid) begin
      r_ptr <= (o_winner == LAST) ? {PW{1'b0}} : (o_winner + PW'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/global_st_arbiter.sv
// -----------------------------------------------------------------------------
// global_st_arbiter
// Shares the global memory write port between N_PE store FIFOs using
// round-robin arbitration into a one-entry output register, and runs the
// flush handshake that tells the controller when every store has landed.
//   clk, rst          : clock, synchronous active-high reset
//   pe_st_req/addr/data : per-PE store FIFO heads (PE i at [i*W +: W])
//   pe_st_gnt         : one-hot pop to the winning FIFO
//   pe_all_stored     : per-PE store-idle flags
//   mem_wr_en/addr/data, mem_wr_rdy : registered memory write port
//   flush_req/busy/done : flush handshake with the controller
//   all_stored        : system-wide store idle
// Optional build macro GLOBAL_ST_ARB_PERF_CNT_EN adds saturating
// perf_stall_cycles and perf_conflict_cycles counters.
// -----------------------------------------------------------------------------
module global_st_arbiter
  import pe_pkg::*;
#(
  parameter int N_PE   = N_PE_ST_ARB,
  parameter int ADDR_L = GLOBAL_MEM_ADDR_L,
  parameter int D_L    = DATA_L,
  parameter int PW     = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PE-1:0]      pe_st_req,
  input  logic [N_PE*ADDR_L-1:0] pe_st_addr,
  input  logic [N_PE*D_L-1:0]  pe_st_data,
  output logic [N_PE-1:0]      pe_st_gnt,
  input  logic [N_PE-1:0]      pe_all_stored,
  output logic                 mem_wr_en,
  output logic [ADDR_L-1:0]    mem_wr_addr,
  output logic [D_L-1:0]       mem_wr_data,
  input  logic                 mem_wr_rdy,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 all_stored
`ifdef GLOBAL_ST_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_conflict_cycles
`endif
);

  logic                 r_mem_wr_en;
  logic [ADDR_L-1:0]    r_mem_wr_addr;
  logic [D_L-1:0]       r_mem_wr_data;
  global_st_arb_state_t r_state;
  global_st_arb_state_t w_state_next;

  logic                 w_load_ok;
  logic                 w_advance;
  logic                 w_gnt_valid;
  logic [PW-1:0]        w_winner;

  // The output register may take a new write when it is empty or draining.
  // Grants are held off during reset so no FIFO is popped into a discarded slot.
  assign w_load_ok = ~r_mem_wr_en | mem_wr_rdy;
  assign w_advance = w_load_ok & ~rst;

  rr_arbiter #(
    .N  (N_PE),
    .PW (PW)
  ) u_rr (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (pe_st_req),
    .i_advance (w_advance),
    .o_gnt     (pe_st_gnt),
    .o_winner  (w_winner),
    .o_valid   (w_gnt_valid)
  );

  // Output register: load the winner, drain when accepted, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= {ADDR_L{1'b0}};
      r_mem_wr_data <= {D_L{1'b0}};
    end else if (w_gnt_valid) begin
      r_mem_wr_en   <= 1'b1;
      r_mem_wr_addr <= pe_st_addr[int'(w_winner)*ADDR_L +: ADDR_L];
      r_mem_wr_data <= pe_st_data[int'(w_winner)*D_L +: D_L];
    end else if (w_load_ok) begin
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= r_mem_wr_addr;
      r_mem_wr_data <= r_mem_wr_data;
    end else begin
      r_mem_wr_en   <= r_mem_wr_en;
      r_mem_wr_addr <= r_mem_wr_addr;
      r_mem_wr_data <= r_mem_wr_data;
    end
  end

  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;

  assign all_stored = (&pe_all_stored) & ~r_mem_wr_en & ~(|pe_st_req);

  // Flush FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush FSM next state; requests outside RUN are ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (flush_req) begin
          w_state_next = FLUSH;
        end else begin
          w_state_next = RUN;
        end
      end
      FLUSH: begin
        if (all_stored) begin
          w_state_next = DONE;
        end else begin
          w_state_next = FLUSH;
        end
      end
      DONE:    w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // Decoded straight from the state register, so both are glitch-free.
  assign flush_busy = (r_state == FLUSH);
  assign flush_done = (r_state == DONE);

`ifdef GLOBAL_ST_ARB_PERF_CNT_EN
  logic        w_cnt_clr;
  logic        w_conflict;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_conflict_cnt;

  assign w_cnt_clr  = (r_state == RUN) & flush_req;
  // Two or more bits set: clearing the lowest set bit leaves something.
  assign w_conflict = |(pe_st_req & (pe_st_req - N_PE'(1)));

  // Saturating stall and conflict counters.
  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_stall_cnt    <= 32'd0;
      r_conflict_cnt <= 32'd0;
    end else begin
      if (r_mem_wr_en && !mem_wr_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end else begin
        r_conflict_cnt <= r_conflict_cnt;
      end
    end
  end

  assign perf_stall_cycles    = r_stall_cnt;
  assign perf_conflict_cycles = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_global_st_arbiter.sv
module tb_global_st_arbiter;

  localparam int N  = 8;
  localparam int AL = 16;
  localparam int DL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    pe_st_req;
  logic [N*AL-1:0] pe_st_addr;
  logic [N*DL-1:0] pe_st_data;
  logic [N-1:0]    pe_st_gnt;
  logic [N-1:0]    pe_all_stored;
  logic            mem_wr_en;
  logic [AL-1:0]   mem_wr_addr;
  logic [DL-1:0]   mem_wr_data;
  logic            mem_wr_rdy;
  logic            flush_req;
  logic            flush_busy;
  logic            flush_done;
  logic            all_stored;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  bit            m_en;
  logic [AL-1:0] m_addr;
  logic [DL-1:0] m_data;
  int            m_state; // 0 idle, 1 flushing, 2 done pulse

  always #5 clk = ~clk;

  global_st_arbiter #(.N_PE(N), .ADDR_L(AL), .D_L(DL)) dut (
    .clk(clk), .rst(rst),
    .pe_st_req(pe_st_req), .pe_st_addr(pe_st_addr), .pe_st_data(pe_st_data),
    .pe_st_gnt(pe_st_gnt), .pe_all_stored(pe_all_stored),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_rdy(mem_wr_rdy), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .all_stored(all_stored)
  );

  function automatic int model_pick();
    if (m_en && !mem_wr_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (pe_st_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    int w;
    logic [N-1:0] g;
    w = model_pick();
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  function automatic bit model_all_stored();
    return (pe_all_stored == {N{1'b1}}) && !m_en && (pe_st_req == '0);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int w;
    bit as;
    if (rst) begin
      m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_state = 0;
      return;
    end
    w  = model_pick();
    as = model_all_stored();
    if (m_state == 0) m_state = flush_req ? 1 : 0;
    else if (m_state == 1) m_state = as ? 2 : 1;
    else m_state = 0;
    if (w >= 0) begin
      m_en   = 1;
      m_addr = pe_st_addr[w*AL +: AL];
      m_data = pe_st_data[w*DL +: DL];
      m_ptr  = (w + 1) % N;
    end else if (!m_en || mem_wr_rdy) begin
      m_en = 0;
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      pe_st_addr[i*AL +: AL] = AL'($urandom);
      pe_st_data[i*DL +: DL] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pe_st_req = '0; pe_all_stored = '1; mem_wr_rdy = 1'b1; flush_req = 1'b0;
    rand_payload();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      finish_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b exp=0", mem_wr_en); end
    total++; if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_wr_addr, mem_wr_data); end
    total++; if (pe_st_gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", pe_st_gnt); end
    total++; if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b%0b exp=00", flush_busy, flush_done); end
    total++; if (dut.u_rr.r_ptr !== 3'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.u_rr.r_ptr); end
    finish_cycle();
  endtask

  task automatic test_single();
    pe_st_req = 8'b0000_0100; mem_wr_rdy = 1'b1;
    pe_st_addr[2*AL +: AL] = 16'h0040;
    pe_st_data[2*DL +: DL] = 32'h0000_00AB;
    @(negedge clk);
    total++; if (pe_st_gnt !== model_gnt()) begin bad++; $display("FAIL single_gnt got=%b exp=%b", pe_st_gnt, model_gnt()); end
    finish_cycle();
    pe_st_req = '0;
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== m_addr || mem_wr_data !== m_data)
      begin bad++; $display("FAIL single_write got=%0b/%h/%h exp=1/%h/%h", mem_wr_en, mem_wr_addr, mem_wr_data, m_addr, m_data); end
    total++; if (dut.u_rr.r_ptr !== 3'(m_ptr)) begin bad++; $display("FAIL single_ptr got=%0d exp=%0d", dut.u_rr.r_ptr, m_ptr); end
    finish_cycle();
  endtask

  task automatic test_fairness();
    pe_st_req = '1; mem_wr_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_payload();
      @(negedge clk);
      total++; if (pe_st_gnt !== model_gnt()) begin bad++; $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, pe_st_gnt, model_gnt()); end
      total++; if (mem_wr_en !== m_en || mem_wr_addr !== m_addr || mem_wr_data !== m_data)
        begin bad++; $display("FAIL fair_write c=%0d got=%0b/%h/%h exp=%0b/%h/%h", c, mem_wr_en, mem_wr_addr, mem_wr_data, m_en, m_addr, m_data); end
      finish_cycle();
    end
    pe_st_req = '0;
  endtask

  task automatic test_backpressure();
    logic [AL-1:0] held_addr;
    pe_st_req = 8'b0001_0001; mem_wr_rdy = 1'b1;
    @(negedge clk);
    finish_cycle();
    held_addr = m_addr;
    mem_wr_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_payload();
      @(negedge clk);
      total++; if (pe_st_gnt !== 8'b0) begin bad++; $display("FAIL bp_gnt c=%0d got=%b exp=0", c, pe_st_gnt); end
      total++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== held_addr) begin bad++; $display("FAIL bp_hold c=%0d got=%0b/%h exp=1/%h", c, mem_wr_en, mem_wr_addr, held_addr); end
      finish_cycle();
    end
    mem_wr_rdy = 1'b1;
    @(negedge clk);
    total++; if (pe_st_gnt !== model_gnt() || pe_st_gnt === 8'b0) begin bad++; $display("FAIL bp_resume got=%b exp=%b", pe_st_gnt, model_gnt()); end
    finish_cycle();
    pe_st_req = '0;
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic test_wrap();
    mem_wr_rdy = 1'b1;
    pe_st_req = 8'b0010_0000;
    @(negedge clk);
    finish_cycle();
    pe_st_req = 8'b1000_0010;
    @(negedge clk);
    total++; if (pe_st_gnt !== 8'b1000_0000) begin bad++; $display("FAIL wrap_first got=%b exp=10000000", pe_st_gnt); end
    finish_cycle();
    pe_st_req = 8'b0000_0010;
    @(negedge clk);
    total++; if (pe_st_gnt !== 8'b0000_0010) begin bad++; $display("FAIL wrap_second got=%b exp=00000010", pe_st_gnt); end
    finish_cycle();
    pe_st_req = '0;
    @(negedge clk);
    total++; if (dut.u_rr.r_ptr !== 3'd2) begin bad++; $display("FAIL wrap_ptr got=%0d exp=2", dut.u_rr.r_ptr); end
    finish_cycle();
  endtask

  task automatic test_flush();
    int done_cnt;
    int cyc;
    done_cnt = 0; cyc = 0;
    mem_wr_rdy = 1'b1;
    pe_st_req = 8'b0010_1000;
    pe_all_stored = 8'b1101_0111;
    flush_req = 1'b1;
    while ((m_state != 0 || cyc == 0) && cyc < 40) begin
      @(negedge clk);
      total++; if (flush_busy !== (m_state == 1) || flush_done !== (m_state == 2))
        begin bad++; $display("FAIL flush_fsm c=%0d got=%0b%0b exp=%0b%0b", cyc, flush_busy, flush_done, m_state == 1, m_state == 2); end
      total++; if (all_stored !== model_all_stored()) begin bad++; $display("FAIL flush_allst c=%0d got=%0b exp=%0b", cyc, all_stored, model_all_stored()); end
      if (flush_done === 1'b1) done_cnt++;
      finish_cycle();
      flush_req = 1'b0;
      // FIFO pop: a granted PE empties and reports stored a little later
      for (int i = 0; i < N; i++) begin
        if (!pe_st_req[i] && !pe_all_stored[i]) pe_all_stored[i] = 1'b1;
      end
      pe_st_req = pe_st_req & ~dut.pe_st_gnt & ~(m_en ? (8'b1 << ((m_ptr + N - 1) % N)) : 8'b0);
      cyc++;
    end
    total++; if (m_state != 0) begin bad++; $display("FAIL flush_timeout state=%0d exp=0", m_state); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL flush_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_flush_idle();
    pe_st_req = '0; pe_all_stored = '1; mem_wr_rdy = 1'b1; flush_req = 1'b1;
    @(negedge clk);
    total++; if (all_stored !== 1'b1) begin bad++; $display("FAIL idle_allst got=%0b exp=1", all_stored); end
    finish_cycle();
    flush_req = 1'b0;
    @(negedge clk);
    total++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b%0b exp=10", flush_busy, flush_done); end
    flush_req = 1'b1; // ignored while busy
    finish_cycle();
    flush_req = 1'b0;
    @(negedge clk);
    total++; if (flush_done !== 1'b1 || flush_busy !== 1'b0) begin bad++; $display("FAIL idle_done got=%0b%0b exp=01", flush_busy, flush_done); end
    finish_cycle();
    @(negedge clk);
    total++; if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin bad++; $display("FAIL idle_after got=%0b%0b exp=00", flush_busy, flush_done); end
    finish_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      pe_st_req     = N'($urandom);
      mem_wr_rdy    = ($urandom_range(3) != 0);
      pe_all_stored = ($urandom_range(3) == 0) ? N'($urandom) : '1;
      flush_req     = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) pe_st_req = '0;
      rand_payload();
      @(negedge clk);
      total++; if (pe_st_gnt !== model_gnt()) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, pe_st_gnt, model_gnt()); end
      total++; if (mem_wr_en !== m_en || mem_wr_addr !== m_addr || mem_wr_data !== m_data)
        begin bad++; $display("FAIL rnd_write c=%0d got=%0b/%h/%h exp=%0b/%h/%h", c, mem_wr_en, mem_wr_addr, mem_wr_data, m_en, m_addr, m_data); end
      total++; if (all_stored !== model_all_stored() || flush_busy !== (m_state == 1) || flush_done !== (m_state == 2))
        begin bad++; $display("FAIL rnd_flush c=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, all_stored, flush_busy, flush_done, model_all_stored(), m_state == 1, m_state == 2); end
      finish_cycle();
    end
    flush_req = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    pe_st_req = '1; pe_all_stored = 8'b0; mem_wr_rdy = 1'b1; flush_req = 1'b1;
    @(negedge clk);
    finish_cycle();
    flush_req = 1'b0; mem_wr_rdy = 1'b0;
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b1 || flush_busy !== 1'b1) begin bad++; $display("FAIL rmw_setup got=%0b%0b exp=11", mem_wr_en, flush_busy); end
    finish_cycle();
    rst = 1'b1;
    @(negedge clk);
    finish_cycle();
    rst = 1'b0; pe_st_req = '0;
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0)
      begin bad++; $display("FAIL rmw_out got=%0b/%h/%h exp=0/0/0", mem_wr_en, mem_wr_addr, mem_wr_data); end
    total++; if (flush_busy !== 1'b0 || flush_done !== 1'b0 || pe_st_gnt !== '0)
      begin bad++; $display("FAIL rmw_fsm got=%0b%0b/%b exp=00/0", flush_busy, flush_done, pe_st_gnt); end
    total++; if (dut.u_rr.r_ptr !== 3'd0) begin bad++; $display("FAIL rmw_ptr got=%0d exp=0", dut.u_rr.r_ptr); end
    finish_cycle();
  endtask

  initial begin
    rst = 1'b1; pe_st_req = '0; pe_st_addr = '0; pe_st_data = '0;
    pe_all_stored = '1; mem_wr_rdy = 1'b1; flush_req = 1'b0;
    m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_state = 0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_flush_idle();
    test_flush();
    test_random();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
